// File: rtl/motor_cmd_pkg.sv
// Constants shared by the UART command framer and the motor control logic.
// Holds the frame header, opcodes, parser state encodings and CMD field positions.
package motor_cmd_pkg;

  localparam logic [7:0] HDR_BYTE = 8'h55;

  localparam logic [1:0] OP_STOP  = 2'b00;
  localparam logic [1:0] OP_FWD   = 2'b01;
  localparam logic [1:0] OP_REV   = 2'b10;
  localparam logic [1:0] OP_BRAKE = 2'b11;

  localparam logic [1:0] S_HDR  = 2'd0;
  localparam logic [1:0] S_CMD  = 2'd1;
  localparam logic [1:0] S_DUTY = 2'd2;
  localparam logic [1:0] S_CSUM = 2'd3;

  localparam int CMD_MOTOR_BIT = 4;
  localparam int CMD_OP_MSB    = 1;
  localparam int CMD_OP_LSB    = 0;

endpackage

// File: rtl/byte_timeout_timer.sv
// Inter-byte idle counter: counts enabled idle cycles and flags expiry
// when the count reaches TIMEOUT_CYCLES in a cycle with no clear.
module byte_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 49152
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count_q, count_d;

  // Saturates at LIMIT so a parked counter never wraps into a false restart.
  always_comb begin
    count_d = count_q;
    if (clear || !enable) begin
      count_d = '0;
    end else if (count_q != LIMIT) begin
      count_d = count_q + CW'(1);
    end
  end

  assign expire = enable && !clear && (count_q == LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Frames UART bytes into motor commands (0x55, CMD, DUTY[, CSUM]) with timeout detection.
// Define CMD_PARSER_CSUM_EN to enable the trailing checksum byte.
module uart_cmd_parser
  import motor_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 49152,
  parameter logic [7:0]  DUTY_MAX       = 8'd250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] RxData,
  input  logic       Rx_Done_Sig,
  output logic       Cmd_Valid_Sig,
  output logic       Cmd_Motor,
  output logic [1:0] Cmd_Op,
  output logic [7:0] Cmd_Duty,
  output logic       Frame_Err_Sig,
  output logic [7:0] Err_Count
);

  logic [1:0] state_q, state_d;
  logic       pend_motor_q, pend_motor_d;
  logic [1:0] pend_op_q, pend_op_d;
  logic       cmd_valid_q, cmd_valid_d;
  logic       cmd_motor_q, cmd_motor_d;
  logic [1:0] cmd_op_q, cmd_op_d;
  logic [7:0] cmd_duty_q, cmd_duty_d;
  logic       frame_err_q, frame_err_d;
  logic [7:0] err_count_q, err_count_d;
`ifdef CMD_PARSER_CSUM_EN
  logic [7:0] pend_duty_q, pend_duty_d;
  logic [7:0] sum_q, sum_d;
`endif

  logic       expire;
  logic       commit;
  logic       fail;
  logic [7:0] commit_duty;

  byte_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (Rx_Done_Sig),
    .enable(state_q != S_HDR),
    .expire(expire)
  );

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    pend_motor_d = pend_motor_q;
    pend_op_d    = pend_op_q;
    cmd_valid_d  = 1'b0;
    cmd_motor_d  = cmd_motor_q;
    cmd_op_d     = cmd_op_q;
    cmd_duty_d   = cmd_duty_q;
    frame_err_d  = 1'b0;
    err_count_d  = err_count_q;
    commit       = 1'b0;
    fail         = 1'b0;
`ifdef CMD_PARSER_CSUM_EN
    pend_duty_d  = pend_duty_q;
    sum_d        = sum_q;
    commit_duty  = pend_duty_q;
`else
    commit_duty  = RxData;
`endif

    // A byte in the expiry cycle takes priority over the timeout.
    if (Rx_Done_Sig) begin
      case (state_q)
        S_HDR: begin
          if (RxData == HDR_BYTE) state_d = S_CMD;
        end
        S_CMD: begin
          pend_motor_d = RxData[CMD_MOTOR_BIT];
          pend_op_d    = RxData[CMD_OP_MSB:CMD_OP_LSB];
`ifdef CMD_PARSER_CSUM_EN
          sum_d        = RxData;
`endif
          state_d      = S_DUTY;
        end
        S_DUTY: begin
`ifdef CMD_PARSER_CSUM_EN
          pend_duty_d = RxData;
          sum_d       = sum_q + RxData;
          state_d     = S_CSUM;
`else
          commit      = 1'b1;
          state_d     = S_HDR;
`endif
        end
`ifdef CMD_PARSER_CSUM_EN
        S_CSUM: begin
          if (RxData == sum_q) commit = 1'b1;
          else                 fail   = 1'b1;
          state_d = S_HDR;
        end
`endif
        default: state_d = S_HDR;
      endcase
    end else if (expire) begin
      fail    = 1'b1;
      state_d = S_HDR;
    end

    if (commit) begin
      cmd_valid_d = 1'b1;
      cmd_motor_d = pend_motor_q;
      cmd_op_d    = pend_op_q;
      cmd_duty_d  = (commit_duty > DUTY_MAX) ? DUTY_MAX : commit_duty;
    end

    if (fail) begin
      frame_err_d = 1'b1;
      if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_HDR;
      pend_motor_q <= 1'b0;
      pend_op_q    <= OP_STOP;
      cmd_valid_q  <= 1'b0;
      cmd_motor_q  <= 1'b0;
      cmd_op_q     <= OP_STOP;
      cmd_duty_q   <= 8'd0;
      frame_err_q  <= 1'b0;
      err_count_q  <= 8'd0;
`ifdef CMD_PARSER_CSUM_EN
      pend_duty_q  <= 8'd0;
      sum_q        <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      pend_motor_q <= pend_motor_d;
      pend_op_q    <= pend_op_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_motor_q  <= cmd_motor_d;
      cmd_op_q     <= cmd_op_d;
      cmd_duty_q   <= cmd_duty_d;
      frame_err_q  <= frame_err_d;
      err_count_q  <= err_count_d;
`ifdef CMD_PARSER_CSUM_EN
      pend_duty_q  <= pend_duty_d;
      sum_q        <= sum_d;
`endif
    end
  end

  assign Cmd_Valid_Sig = cmd_valid_q;
  assign Cmd_Motor     = cmd_motor_q;
  assign Cmd_Op        = cmd_op_q;
  assign Cmd_Duty      = cmd_duty_q;
  assign Frame_Err_Sig = frame_err_q;
  assign Err_Count     = err_count_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser; follows CMD_PARSER_CSUM_EN for frame length.
// Uses a short TIMEOUT_CYCLES so timeout and saturation scenarios stay quick.
module tb_uart_cmd_parser;

  localparam int unsigned TO = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       cmd_valid;
  logic       cmd_motor;
  logic [1:0] cmd_op;
  logic [7:0] cmd_duty;
  logic       frame_err;
  logic [7:0] err_count;

  int checks   = 0;
  int failures = 0;
  int n_valid  = 0;
  int n_err    = 0;
  int n_both   = 0;
  int exp_errs = 0;
  int snap_valid;
  int snap_err;

  always #5 clk = ~clk;

  uart_cmd_parser #(
    .TIMEOUT_CYCLES(TO),
    .DUTY_MAX      (8'd250)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .RxData       (rx_data),
    .Rx_Done_Sig  (rx_done),
    .Cmd_Valid_Sig(cmd_valid),
    .Cmd_Motor    (cmd_motor),
    .Cmd_Op       (cmd_op),
    .Cmd_Duty     (cmd_duty),
    .Frame_Err_Sig(frame_err),
    .Err_Count    (err_count)
  );

  // Pulse tally, sampled at the active edge (values from the previous cycle).
  always @(posedge clk) begin
    if (cmd_valid) n_valid++;
    if (frame_err) n_err++;
    if (cmd_valid && frame_err) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the byte is sampled at the next posedge and the task
  // returns on the following negedge, where that byte's outputs are visible.
  task automatic put(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] duty);
    put(8'h55);
    put(cmd);
    put(duty);
`ifdef CMD_PARSER_CSUM_EN
    put(8'(cmd + duty));
`endif
  endtask

  initial begin
    reset   = 1'b1;
    rx_done = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_valid", 32'(cmd_valid), 32'd0);
    check("rst_motor", 32'(cmd_motor), 32'd0);
    check("rst_op",    32'(cmd_op),    32'd0);
    check("rst_duty",  32'(cmd_duty),  32'd0);
    check("rst_err",   32'(frame_err), 32'd0);
    check("rst_cnt",   32'(err_count), 32'd0);

    // Good frame 55 11 80 [91]
    send_frame(8'h11, 8'h80);
    check("good_valid", 32'(cmd_valid), 32'd1);
    check("good_motor", 32'(cmd_motor), 32'd1);
    check("good_op",    32'(cmd_op),    32'd1);
    check("good_duty",  32'(cmd_duty),  32'h80);
    check("good_err",   32'(frame_err), 32'd0);

    // Clamp frame follows back-to-back: 55 02 FF [01]
    send_frame(8'h02, 8'hFF);
    check("clamp_valid", 32'(cmd_valid), 32'd1);
    check("clamp_motor", 32'(cmd_motor), 32'd0);
    check("clamp_op",    32'(cmd_op),    32'd2);
    check("clamp_duty",  32'(cmd_duty),  32'hFA);
    @(negedge clk);
    check("valid_one_cycle", 32'(cmd_valid), 32'd0);
    check("clamp_cnt",       32'(err_count), 32'd0);

`ifdef CMD_PARSER_CSUM_EN
    // Bad checksum 55 11 80 90
    put(8'h55); put(8'h11); put(8'h80); put(8'h90);
    exp_errs++;
    check("badcs_err",   32'(frame_err), 32'd1);
    check("badcs_valid", 32'(cmd_valid), 32'd0);
    check("badcs_motor", 32'(cmd_motor), 32'd0);
    check("badcs_op",    32'(cmd_op),    32'd2);
    check("badcs_duty",  32'(cmd_duty),  32'hFA);
    check("badcs_cnt",   32'(err_count), 32'(exp_errs));
`endif

    // Timeout after 55 11: expiry cycle, then error pulse one cycle later
    put(8'h55); put(8'h11);
    repeat (TO) @(negedge clk);
    check("to_before", 32'(frame_err), 32'd0);
    @(negedge clk);
    exp_errs++;
    check("to_pulse", 32'(frame_err), 32'd1);
    check("to_cnt",   32'(err_count), 32'(exp_errs));
    @(negedge clk);
    check("to_one_cycle", 32'(frame_err), 32'd0);
    send_frame(8'h03, 8'h10);
    check("post_to_valid", 32'(cmd_valid), 32'd1);
    check("post_to_motor", 32'(cmd_motor), 32'd0);
    check("post_to_op",    32'(cmd_op),    32'd3);
    check("post_to_duty",  32'(cmd_duty),  32'h10);

    // Byte lands exactly in the expiry cycle: accepted, no error
    put(8'h55);
    repeat (TO) @(negedge clk);
    put(8'h11);
    check("edge_err", 32'(frame_err), 32'd0);
    put(8'h80);
`ifdef CMD_PARSER_CSUM_EN
    put(8'h91);
`endif
    check("edge_valid", 32'(cmd_valid), 32'd1);
    check("edge_motor", 32'(cmd_motor), 32'd1);
    check("edge_duty",  32'(cmd_duty),  32'h80);
    check("edge_cnt",   32'(err_count), 32'(exp_errs));

    // Junk before header is ignored
    put(8'h00); put(8'hAA); put(8'h33);
    send_frame(8'h02, 8'h40);
    check("junk_valid", 32'(cmd_valid), 32'd1);
    check("junk_op",    32'(cmd_op),    32'd2);
    check("junk_duty",  32'(cmd_duty),  32'h40);
    check("junk_cnt",   32'(err_count), 32'(exp_errs));

    // Reset mid-frame abandons the partial frame silently
    put(8'h55); put(8'h11);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_errs   = 0;
    snap_valid = n_valid;
    snap_err   = n_err;
    put(8'h80); put(8'h91);
    repeat (TO + 4) @(negedge clk);
    check("rstmid_valids", 32'(n_valid - snap_valid), 32'd0);
    check("rstmid_errs",   32'(n_err - snap_err),     32'd0);
    check("rstmid_duty",   32'(cmd_duty),             32'd0);
    check("rstmid_cnt",    32'(err_count),            32'd0);

    // Saturation over 300 errored frames
    snap_err = n_err;
    for (int i = 0; i < 300; i++) begin
`ifdef CMD_PARSER_CSUM_EN
      put(8'h55); put(8'h11); put(8'h80); put(8'h90);
`else
      put(8'h55);
      repeat (TO + 2) @(negedge clk);
`endif
    end
    repeat (3) @(negedge clk);
    check("sat_cnt",    32'(err_count),        32'd255);
    check("sat_pulses", 32'(n_err - snap_err), 32'd300);

    check("no_overlap", 32'(n_both),  32'd0);
    check("valid_total", 32'(n_valid), 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
